feature_alu_cluster_p: RTL and testbench

Parametrised next-generation 2-stage feature ALU cluster for the TFE. It covers NCH per-packet metric channels, for example pkt_size and pkt_arit. Per accepted packet it merges the current sample into historical max/min/sum/count/vector state and writes the result back to the feature cache. When the packet count reaches the threshold, it runs a shared sequential divider for per-channel averages, then emits a final record to main feature memory under valid/ready backpressure.

---
 rtl/feature_alu_cluster_p.sv | 154 +++++++++++++++
 tb/tb_feature_alu_cluster_p.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/feature_alu_cluster_p.sv
// feature_alu_cluster_p: two-stage per-flow feature merge with cache write-back and thresholded average emission
module feature_alu_cluster_p #(
  parameter int DW = 8,
  parameter int NCH = 2,
  parameter int VEC_DEPTH = 4,
  parameter int CNT_W = 8,
  parameter int HASH_W = 32,
  parameter int SW = DW + CNT_W
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          i_v,
  output logic                                          o_rdy,
  input  logic [HASH_W-1:0]                             i_hash,
  input  logic [CNT_W-1:0]                              i_cnt,
  input  logic [CNT_W-1:0]                              i_thrh,
  input  logic [NCH*DW-1:0]                             i_cur,
  input  logic [NCH*DW-1:0]                             i_hist_max,
  input  logic [NCH*DW-1:0]                             i_hist_min,
  input  logic [NCH*SW-1:0]                             i_hist_sum,
  input  logic [NCH*VEC_DEPTH*DW-1:0]                   i_hist_vec,
  output logic                                          o_cache_we,
  output logic [HASH_W-1:0]                             o_cache_addr,
  output logic [CNT_W+NCH*(2*DW+SW+VEC_DEPTH*DW)-1:0]   o_cache_data,
  output logic                                          o_mem_v,
  input  logic                                          i_mem_rdy,
  output logic [HASH_W-1:0]                             o_mem_addr,
  output logic [CNT_W+NCH*(3*DW+VEC_DEPTH*DW)-1:0]      o_mem_data
);
  localparam int SW_W = $clog2(SW);

  typedef enum logic [1:0] {IDLE, UPD, DIV, EMIT} state_t;

  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt_new, cnt_r;
  logic [NCH*DW-1:0] m_max, m_min, max_r, min_r, avg_n;
  logic [NCH*SW-1:0] m_sum, sum_r;
  logic [NCH*VEC_DEPTH*DW-1:0] m_vec, vec_r;
  logic [HASH_W-1:0] hash_r;
  logic reach_r, last;
  logic [SW_W-1:0] step_r;
  logic [SW-1:0] rem_r [NCH];
  logic [SW-1:0] rem_n [NCH];
  logic [SW-1:0] quo_r [NCH];
  logic [SW-1:0] quo_n [NCH];

  assign o_rdy = state == IDLE;
  assign o_cache_we = state == UPD;
  assign o_mem_v = state == EMIT;
  assign o_cache_addr = hash_r;
  assign o_cache_data = {vec_r, sum_r, min_r, max_r, cnt_r};
  assign last = step_r == SW_W'(SW - 1);

  // merge the current sample into the historical state; a zero count starts a fresh flow
  always_comb begin
    logic [DW-1:0] cur, hmx, hmn;
    logic [SW:0] sx;
    logic new_flow;
    new_flow = i_cnt == '0;
    cnt_new = &i_cnt ? i_cnt : i_cnt + CNT_W'(1);
    m_max = '0;
    m_min = '0;
    m_sum = '0;
    m_vec = '0;
    for (int c = 0; c < NCH; c++) begin
      cur = i_cur[c*DW +: DW];
      hmx = i_hist_max[c*DW +: DW];
      hmn = i_hist_min[c*DW +: DW];
      sx = {1'b0, i_hist_sum[c*SW +: SW]} + (SW+1)'(cur);
      m_max[c*DW +: DW] = (new_flow || cur > hmx) ? cur : hmx;
      m_min[c*DW +: DW] = (new_flow || cur < hmn) ? cur : hmn;
      m_sum[c*SW +: SW] = new_flow ? SW'(cur) : sx[SW] ? '1 : sx[SW-1:0];
      for (int v = 0; v < VEC_DEPTH; v++)
        m_vec[(c*VEC_DEPTH+v)*DW +: DW] = (i_cnt == CNT_W'(v)) ? cur :
                                          new_flow ? '0 : i_hist_vec[(c*VEC_DEPTH+v)*DW +: DW];
    end
  end

  // one restoring-division step per channel, quotient clamped to the feature width
  always_comb begin
    logic [SW:0] sh;
    logic ge;
    avg_n = '0;
    for (int c = 0; c < NCH; c++) begin
      sh = {rem_r[c], quo_r[c][SW-1]};
      ge = sh >= (SW+1)'(cnt_r);
      rem_n[c] = SW'(ge ? sh - (SW+1)'(cnt_r) : sh);
      quo_n[c] = {quo_r[c][SW-2:0], ge};
      avg_n[c*DW +: DW] = |quo_n[c][SW-1:DW] ? '1 : quo_n[c][DW-1:0];
    end
  end

  // sequencing: accept in IDLE, write back in UPD, divide when threshold hit, hold record until taken
  always_comb begin
    state_nxt = state == IDLE ? (i_v ? UPD : IDLE) :
                state == UPD  ? (reach_r ? DIV : IDLE) :
                state == DIV  ? (last ? EMIT : DIV) :
                                (i_mem_rdy ? IDLE : EMIT);
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end

  // merged state capture, divider seeding/stepping and final record latch
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
      max_r <= '0;
      min_r <= '0;
      sum_r <= '0;
      vec_r <= '0;
      hash_r <= '0;
      reach_r <= 1'b0;
      step_r <= '0;
      o_mem_addr <= '0;
      o_mem_data <= '0;
      for (int c = 0; c < NCH; c++) begin
        rem_r[c] <= '0;
        quo_r[c] <= '0;
      end
    end else begin
      if (state == IDLE && i_v) begin
        cnt_r <= cnt_new;
        max_r <= m_max;
        min_r <= m_min;
        sum_r <= m_sum;
        vec_r <= m_vec;
        hash_r <= i_hash;
        reach_r <= (i_thrh != '0) && (cnt_new == i_thrh);
      end
      if (state == UPD) begin
        step_r <= '0;
        for (int c = 0; c < NCH; c++) begin
          rem_r[c] <= '0;
          quo_r[c] <= sum_r[c*SW +: SW];
        end
      end
      if (state == DIV) begin
        step_r <= step_r + SW_W'(1);
        for (int c = 0; c < NCH; c++) begin
          rem_r[c] <= rem_n[c];
          quo_r[c] <= quo_n[c];
        end
        if (last) begin
          o_mem_addr <= hash_r;
          o_mem_data <= {vec_r, avg_n, min_r, max_r, cnt_r};
        end
      end
    end
  end
endmodule

// File: tb/tb_feature_alu_cluster_p.sv
// tb_feature_alu_cluster_p: directed scoreboard bench for the feature ALU cluster
module tb_feature_alu_cluster_p;
  logic clk = 0, rst = 1, i_v = 0, i_mem_rdy = 1;
  logic o_rdy, o_cache_we, o_mem_v;
  logic [31:0] i_hash = 0, o_cache_addr, o_mem_addr;
  logic [7:0] i_cnt = 0, i_thrh = 0;
  logic [15:0] i_cur = 0, i_hist_max = 0, i_hist_min = 0;
  logic [31:0] i_hist_sum = 0;
  logic [63:0] i_hist_vec = 0;
  logic [135:0] o_cache_data;
  logic [119:0] o_mem_data;
  int tests = 0, fails = 0;

  typedef struct {logic [31:0] a; logic [135:0] d;} cx_t;
  typedef struct {logic [31:0] a; logic [119:0] d;} mx_t;
  cx_t cq[$];
  mx_t mq[$];

  feature_alu_cluster_p dut (
    .clk(clk), .rst(rst), .i_v(i_v), .o_rdy(o_rdy), .i_hash(i_hash), .i_cnt(i_cnt),
    .i_thrh(i_thrh), .i_cur(i_cur), .i_hist_max(i_hist_max), .i_hist_min(i_hist_min),
    .i_hist_sum(i_hist_sum), .i_hist_vec(i_hist_vec), .o_cache_we(o_cache_we),
    .o_cache_addr(o_cache_addr), .o_cache_data(o_cache_data), .o_mem_v(o_mem_v),
    .i_mem_rdy(i_mem_rdy), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [135:0] cpk(input logic [7:0] cnt, mx0, mx1, mn0, mn1,
                                       input logic [15:0] s0, s1, input logic [31:0] v0, v1);
    return {v1, v0, s1, s0, mn1, mn0, mx1, mx0, cnt};
  endfunction

  function automatic logic [119:0] mpk(input logic [7:0] cnt, mx0, mx1, mn0, mn1, a0, a1,
                                       input logic [31:0] v0, v1);
    return {v1, v0, a1, a0, mn1, mn0, mx1, mx0, cnt};
  endfunction

  task automatic push_mem(input logic [31:0] a, input logic [119:0] d);
    mx_t m;
    m.a = a;
    m.d = d;
    mq.push_back(m);
  endtask

  task automatic send(input logic [31:0] h, input logic [7:0] cnt, thrh, c0, c1, mx0, mx1, mn0, mn1,
                      input logic [15:0] s0, s1, input logic [31:0] v0, v1, input logic [135:0] exp);
    cx_t e;
    int n = 0;
    while (!o_rdy && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("send_rdy_timeout", o_rdy, 1);
    e.a = h;
    e.d = exp;
    cq.push_back(e);
    i_hash = h; i_cnt = cnt; i_thrh = thrh; i_cur = {c1, c0};
    i_hist_max = {mx1, mx0}; i_hist_min = {mn1, mn0}; i_hist_sum = {s1, s0}; i_hist_vec = {v1, v0};
    i_v = 1;
    @(posedge clk);
    #1 i_v = 0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (o_cache_we) begin
        if (cq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL cache_unexpected: got write addr %0h expected none", o_cache_addr);
        end else begin
          cx_t e;
          e = cq.pop_front();
          chk("cache_addr", o_cache_addr, e.a);
          chk("cache_data", o_cache_data, e.d);
        end
      end
      if (o_mem_v && i_mem_rdy) begin
        if (mq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL mem_unexpected: got record addr %0h expected none", o_mem_addr);
        end else begin
          mx_t m;
          m = mq.pop_front();
          chk("mem_addr", o_mem_addr, m.a);
          chk("mem_data", o_mem_data, m.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int nv;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_rdy", o_rdy, 1);
    chk("rst_cache_we", o_cache_we, 0);
    chk("rst_mem_v", o_mem_v, 0);
    chk("rst_cache_data", o_cache_data, 0);
    chk("rst_mem_data", o_mem_data, 0);
    chk("rst_addrs", {o_cache_addr, o_mem_addr}, 0);

    send(32'hA0B1C2D3, 0, 4, 100, 5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
         cpk(1, 100, 5, 100, 5, 100, 5, 32'h64, 32'h05));
    @(negedge clk);
    chk("upd_rdy_low", o_rdy, 0);
    @(negedge clk);
    chk("new_flow_idle_rdy", o_rdy, 1);
    chk("new_flow_no_mem", o_mem_v, 0);

    send(32'hA0B1C2D3, 1, 4, 60, 3, 100, 5, 100, 5, 100, 5, 32'h64, 32'h05,
         cpk(2, 100, 5, 60, 3, 160, 8, 32'h3C64, 32'h0305));
    send(32'hA0B1C2D3, 2, 4, 200, 9, 100, 5, 60, 3, 160, 8, 32'h3C64, 32'h0305,
         cpk(3, 200, 9, 60, 3, 360, 17, 32'hC83C64, 32'h090305));
    push_mem(32'hA0B1C2D3, mpk(4, 200, 9, 40, 3, 100, 6, 32'h28C83C64, 32'h07090305));
    send(32'hA0B1C2D3, 3, 4, 40, 7, 200, 9, 60, 3, 360, 17, 32'hC83C64, 32'h090305,
         cpk(4, 200, 9, 40, 3, 400, 24, 32'h28C83C64, 32'h07090305));
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!o_mem_v && k < 40);
    chk("mem_latency", k, 18);
    @(negedge clk);
    chk("after_emit_mem_v", o_mem_v, 0);
    chk("after_emit_rdy", o_rdy, 1);

    @(posedge clk);
    #1 i_mem_rdy = 0;
    push_mem(32'h12345678, mpk(2, 8'h20, 4, 8'h08, 3, 8'hFF, 7, 32'h1020, 32'h0403));
    send(32'h12345678, 1, 2, 8'h10, 4, 8'h20, 3, 8'h08, 3, 16'h1000, 10, 32'h20, 32'h03,
         cpk(2, 8'h20, 4, 8'h08, 3, 16'h1010, 14, 32'h1020, 32'h0403));
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!o_mem_v && k < 40);
    chk("bp_mem_latency", k, 18);
    for (int i = 0; i < 5; i++) begin
      chk("bp_mem_v_held", o_mem_v, 1);
      chk("bp_rdy_low", o_rdy, 0);
      chk("bp_data_stable", o_mem_data, mpk(2, 8'h20, 4, 8'h08, 3, 8'hFF, 7, 32'h1020, 32'h0403));
      chk("bp_addr_stable", o_mem_addr, 32'h12345678);
      @(negedge clk);
    end
    @(posedge clk);
    #1 i_mem_rdy = 1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_mem_v", o_mem_v, 0);
    chk("bp_release_rdy", o_rdy, 1);

    send(32'h0BADF00D, 255, 0, 8'h20, 8'h01, 8'h10, 8'h80, 8'h10, 8'h02, 16'hFFF0, 16'h0100,
         32'h11223344, 32'h55667788,
         cpk(255, 8'h20, 8'h80, 8'h10, 8'h01, 16'hFFFF, 16'h0101, 32'h11223344, 32'h55667788));
    @(negedge clk);
    chk("sat_upd_rdy", o_rdy, 0);
    @(negedge clk);
    chk("sat_idle_rdy", o_rdy, 1);
    chk("sat_no_mem", o_mem_v, 0);

    send(32'hCAFEBABE, 6, 9, 77, 200, 90, 100, 80, 50, 500, 300, 32'hA1B2C3D4, 32'h01020304,
         cpk(7, 90, 200, 77, 50, 577, 500, 32'hA1B2C3D4, 32'h01020304));
    @(negedge clk);
    @(negedge clk);
    chk("ovf_idle_rdy", o_rdy, 1);

    send(32'h55AA55AA, 0, 1, 9, 9, 0, 0, 0, 0, 0, 0, 0, 0,
         cpk(1, 9, 9, 9, 9, 9, 9, 32'h09, 32'h09));
    repeat (5) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("midrst_rdy", o_rdy, 1);
    chk("midrst_mem_v", o_mem_v, 0);
    chk("midrst_cache_we", o_cache_we, 0);
    chk("midrst_mem_data", o_mem_data, 0);
    chk("midrst_cache_data", o_cache_data, 0);
    nv = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_mem_v) nv++;
    end
    chk("midrst_no_emit", nv, 0);

    chk("cache_queue_drained", cq.size(), 0);
    chk("mem_queue_drained", mq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
